// File: rtl/axi_imem_slave.sv
// axi_imem_slave: single-outstanding AXI read slave in front of a synchronous 64-bit instruction memory
module axi_imem_slave #(
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          MEM_AW    = 16,
    parameter int          LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        ARID,
    input  logic [63:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [3:0]        RID,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_ren,
    output logic [MEM_AW-1:0] mem_raddr,
    input  logic [63:0]       mem_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, READ, RESP} state_t;

    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [3:0]        r_id;
    logic [63:0]       r_addr;
    logic [7:0]        r_beats;
    logic [2:0]        r_size;
    logic              r_fixed;
    logic              r_slverr;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [1:0]        r_rresp;
    logic [63:0]       r_rdata;
    logic [3:0]        r_rid;
    logic              r_ren;
    logic [MEM_AW-1:0] r_raddr;

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_ar_slv;
    logic [63:0]       w_inc;
    logic [63:0]       w_nxt_addr;
    logic              w_nxt_slv;
    logic [63:0]       w_nxt_off;
    logic              w_nxt_ok;
    logic [63:0]       w_off;
    logic              w_inr;
    logic [63:0]       w_sh;
    logic [63:0]       w_mask;
    logic              w_goto_read;

    assign w_ar_hs    = ARVALID & r_arready;
    assign w_r_hs     = r_rvalid & RREADY;
    assign w_ar_slv   = ARBURST[1] | ARSIZE[2];
    assign w_inc      = r_fixed ? 64'd0 : 64'd1 << r_size;
    // Address of the beat about to enter READ: fresh request, next burst beat, or the waiting one
    assign w_nxt_addr = (r_state == IDLE) ? ARADDR : (r_state == RESP) ? r_addr + w_inc : r_addr;
    assign w_nxt_slv  = (r_state == IDLE) ? w_ar_slv : r_slverr;
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range
    assign w_nxt_off  = w_nxt_addr - BASE_ADDR;
    assign w_nxt_ok   = !w_nxt_slv && ((w_nxt_off >> (MEM_AW + 3)) == 64'd0);
    assign w_off      = r_addr - BASE_ADDR;
    assign w_inr      = (w_off >> (MEM_AW + 3)) == 64'd0;
    // Right-justify the addressed bytes so the fetch stage always reads from bit 0
    assign w_sh       = mem_rdata >> {r_addr[2:0], 3'b000};
    assign w_mask     = (r_size[1:0] == 2'd3) ? '1 : (64'd1 << (7'd8 << r_size[1:0])) - 64'd1;
    assign w_goto_read = ((r_state == IDLE) && w_ar_hs && (LATENCY == 0)) ||
                         ((r_state == WAIT) && (r_cnt == LAT_M1)) ||
                         ((r_state == RESP) && w_r_hs && (r_beats != 8'd0));

    assign ARREADY   = r_arready;
    assign RID       = r_rid;
    assign RDATA     = r_rdata;
    assign RRESP     = r_rresp;
    assign RLAST     = r_rlast;
    assign RVALID    = r_rvalid;
    assign mem_ren   = r_ren;
    assign mem_raddr = r_raddr;

    // Read FSM: accept one AR, wait LATENCY, then one READ/RESP pair per beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_id      <= '0;
            r_addr    <= '0;
            r_beats   <= '0;
            r_size    <= '0;
            r_fixed   <= 1'b0;
            r_slverr  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= '0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_ren     <= 1'b0;
            r_raddr   <= '0;
        end else begin
            r_ren <= w_goto_read && w_nxt_ok;
            if (w_goto_read)
                r_raddr <= w_nxt_off[MEM_AW+2:3];
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_id      <= ARID;
                        r_addr    <= ARADDR;
                        r_beats   <= ARLEN;
                        r_size    <= ARSIZE;
                        r_fixed   <= (ARBURST == 2'b00);
                        r_slverr  <= w_ar_slv;
                        r_cnt     <= '0;
                        if (LATENCY == 0)
                            r_state <= READ;
                        else
                            r_state <= WAIT;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == LAT_M1)
                        r_state <= READ;
                end
                READ: r_state <= RESP;
                RESP: begin
                    // First RESP cycle waits for the memory word, then the beat is presented
                    if (!r_rvalid) begin
                        r_rvalid <= 1'b1;
                        r_rid    <= r_id;
                        r_rlast  <= (r_beats == 8'd0);
                        r_rresp  <= r_slverr ? 2'b10 : w_inr ? 2'b00 : 2'b11;
                        r_rdata  <= (!r_slverr && w_inr) ? (w_sh & w_mask) : '0;
                    end else if (RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_beats == 8'd0) begin
                            r_state   <= IDLE;
                            r_arready <= 1'b1;
                        end else begin
                            r_beats <= r_beats - 8'd1;
                            r_addr  <= w_nxt_addr;
                            r_state <= READ;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_imem_slave.sv
// tb_axi_imem_slave: directed vector bench for axi_imem_slave with a synchronous memory model
module tb_axi_imem_slave;
    localparam int LAT = 2;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [1:0]  resp;
        logic [15:0] idx;
        logic        wordwise;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [63:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[12];

    axi_imem_slave #(.BASE_ADDR(64'h8000_0000), .MEM_AW(16), .LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word(input logic [15:0] i);
        return 64'h1122_3344_5566_7788 ^ ({48'd0, i} * 64'h0001_0001_0001_0001);
    endfunction

    always @(posedge clk) if (mem_ren) mem_rdata <= word(mem_raddr);

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic xfer(input vec_t v, input int stall_b, input int stall_n);
        int k;
        int ren_k;
        logic [15:0] ren_a;
        logic [15:0] ei;
        logic [63:0] ed;
        @(negedge clk);
        ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARSIZE = v.size; ARBURST = v.burst; ARVALID = 1'b1;
        k = 0;
        while (!ARREADY && k < 20) begin @(negedge clk); k++; end
        chk("ar_accept", 64'(ARREADY), 64'd1);
        @(negedge clk);
        ARVALID = 1'b0;
        chk("ar_busy", 64'(ARREADY), 64'd0);
        for (int b = 0; b <= int'(v.len); b++) begin
            k = 0; ren_k = -1; ren_a = '0;
            while (!RVALID && k < 40) begin
                if (mem_ren && ren_k < 0) begin ren_k = k; ren_a = mem_raddr; end
                @(negedge clk);
                k++;
            end
            ei = v.wordwise ? v.idx + 16'(b) : v.idx;
            ed = v.wordwise ? word(ei) : v.data;
            chk("rvalid_lat", 64'(k), 64'((b == 0) ? LAT + 2 : 2));
            chk("ren_lat", 64'(ren_k), 64'((v.resp != 2'b00) ? -1 : (b == 0) ? LAT : 0));
            if (ren_k >= 0) chk("raddr", 64'(ren_a), 64'(ei));
            chk("rdata", RDATA, ed);
            chk("rresp", 64'(RRESP), 64'(v.resp));
            chk("rlast", 64'(RLAST), 64'(b == int'(v.len)));
            chk("rid", 64'(RID), 64'(v.id));
            if (b == stall_b) repeat (stall_n) begin
                @(negedge clk);
                chk("hold_valid", 64'(RVALID), 64'd1);
                chk("hold_data", RDATA, ed);
                chk("hold_last", 64'(RLAST), 64'(b == int'(v.len)));
            end
            RREADY = 1'b1;
            @(negedge clk);
            RREADY = 1'b0;
        end
        chk("idle_ready", 64'(ARREADY), 64'd1);
        chk("rvalid_drop", 64'(RVALID), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        logic bad;
        vec_t v;
        tbl[0]  = '{4'd5, 64'h8000_0000, 8'd0, 3'd2, 2'b01, 64'h0000_0000_5566_7788, 2'b00, 16'd0,      1'b0};
        tbl[1]  = '{4'd5, 64'h8000_0004, 8'd0, 3'd2, 2'b01, 64'h0000_0000_1122_3344, 2'b00, 16'd0,      1'b0};
        tbl[2]  = '{4'd3, 64'h8000_0003, 8'd0, 3'd0, 2'b01, 64'h0000_0000_0000_0055, 2'b00, 16'd0,      1'b0};
        tbl[3]  = '{4'd7, 64'h8000_0006, 8'd0, 3'd1, 2'b01, 64'h0000_0000_0000_1122, 2'b00, 16'd0,      1'b0};
        tbl[4]  = '{4'd1, 64'h8000_0000, 8'd0, 3'd3, 2'b01, 64'h1122_3344_5566_7788, 2'b00, 16'd0,      1'b0};
        tbl[5]  = '{4'd2, 64'h7FFF_FFF8, 8'd1, 3'd2, 2'b01, 64'h0,                   2'b11, 16'd0,      1'b0};
        tbl[6]  = '{4'd9, 64'h8000_0008, 8'd2, 3'd3, 2'b00, 64'h1123_3345_5567_7789, 2'b00, 16'd1,      1'b0};
        tbl[7]  = '{4'd4, 64'h8000_0000, 8'd0, 3'd2, 2'b10, 64'h0,                   2'b10, 16'd0,      1'b0};
        tbl[8]  = '{4'd6, 64'h8000_0000, 8'd0, 3'd4, 2'b01, 64'h0,                   2'b10, 16'd0,      1'b0};
        tbl[9]  = '{4'd8, 64'h8007_FFF8, 8'd0, 3'd3, 2'b01, 64'hEEDD_CCBB_AA99_8877, 2'b00, 16'hFFFF,   1'b0};
        tbl[10] = '{4'd10, 64'h8008_0000, 8'd0, 3'd3, 2'b01, 64'h0,                  2'b11, 16'd0,      1'b0};
        tbl[11] = '{4'd11, 64'h8000_0000, 8'd1, 3'd2, 2'b11, 64'h0,                  2'b10, 16'd0,      1'b0};
        rstn = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        #2;
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_ren", 64'(mem_ren), 64'd0);
        chk("rst_rdata", RDATA, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_arready", 64'(ARREADY), 64'd1);
        for (int i = 0; i < 12; i++) xfer(tbl[i], -1, 0);
        // Four-beat INCR burst with the second beat stalled three cycles
        v = '{4'd12, 64'h8000_0010, 8'd3, 3'd3, 2'b01, 64'h0, 2'b00, 16'd2, 1'b1};
        xfer(v, 1, 3);
        // Reset asserted while the second beat of a four-beat burst is presented
        @(negedge clk);
        ARID = 4'd13; ARADDR = 64'h8000_0000; ARLEN = 8'd3; ARSIZE = 3'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        k = 0;
        while (!ARREADY && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        ARVALID = 1'b0;
        k = 0;
        while (!RVALID && k < 40) begin @(negedge clk); k++; end
        RREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0;
        k = 0;
        while (!RVALID && k < 40) begin @(negedge clk); k++; end
        chk("mid_beat2_valid", 64'(RVALID), 64'd1);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(RVALID), 64'd0);
        chk("mid_rst_arready", 64'(ARREADY), 64'd0);
        chk("mid_rst_rlast", 64'(RLAST), 64'd0);
        chk("mid_rst_rdata", RDATA, 64'd0);
        chk("mid_rst_rid", 64'(RID), 64'd0);
        chk("mid_rst_ren", 64'(mem_ren), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rel_arready", 64'(ARREADY), 64'd1);
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (RVALID || mem_ren) bad = 1'b1;
        end
        chk("no_stale_beats", 64'(bad), 64'd0);
        xfer(tbl[0], -1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
